// File: rtl/fpu_add_arbiter_if.sv
// Client and adder handshake bundle for the shared FP adder arbiter.
// master = arbiter side, slave = requesters plus adder.
`timescale 1ns/1ps
interface fpu_add_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]         rsp_z;
  logic [NUM_REQ-1:0]       rsp_ready;

  logic [WIDTH-1:0]         add_a;
  logic [WIDTH-1:0]         add_b;
  logic                     add_a_stb;
  logic                     add_b_stb;
  logic                     add_a_ack;
  logic                     add_b_ack;
  logic                     add_start;
  logic [WIDTH-1:0]         add_z;
  logic                     add_z_stb;
  logic                     add_z_ack;

  modport master (
    input  req_valid, req_a, req_b, rsp_ready,
    input  add_a_ack, add_b_ack, add_z, add_z_stb,
    output req_ready, rsp_valid, rsp_z,
    output add_a, add_b, add_a_stb, add_b_stb, add_start, add_z_ack
  );

  modport slave (
    output req_valid, req_a, req_b, rsp_ready,
    output add_a_ack, add_b_ack, add_z, add_z_stb,
    input  req_ready, rsp_valid, rsp_z,
    input  add_a, add_b, add_a_stb, add_b_stb, add_start, add_z_ack
  );
endinterface

// File: rtl/fpu_add_arbiter.sv
// Round-robin arbiter sharing one FP adder among NUM_REQ requesters,
// one operation in flight: accept, load operands, wait for sum, respond.
`timescale 1ns/1ps
module fpu_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  fpu_add_arbiter_if.master          bus,
  output logic                       busy_o,
  output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
  output logic [CNT_W-1:0]           op_count_o
);

  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_Z,
    RESP
  } state_t;

  state_t             state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     grant_q, grant_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   z_q, z_d;
  logic               a_stb_q, a_stb_d;
  logic               b_stb_q, b_stb_d;
  logic               start_q, start_d;
  logic               z_ack_q, z_ack_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic               pick_found;
  logic [IDW-1:0]     pick_idx;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;

  // Scan downward from the farthest offset so the nearest valid bit at or
  // after the pointer is the one left standing.
  always_comb begin
    int idx;
    pick_found = 1'b0;
    pick_idx   = '0;
    idx        = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (bus.req_valid[idx]) begin
        pick_found = 1'b1;
        pick_idx   = IDW'(idx);
      end
    end
  end

  assign sel_a = bus.req_a[pick_idx*WIDTH +: WIDTH];
  assign sel_b = bus.req_b[pick_idx*WIDTH +: WIDTH];

  // The accept is combinational so the strobes can rise on the very next cycle.
  always_comb begin
    bus.req_ready = '0;
    if (state_q == IDLE && pick_found && !rst) begin
      bus.req_ready[pick_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    a_d         = a_q;
    b_d         = b_q;
    z_d         = z_q;
    a_stb_d     = a_stb_q;
    b_stb_d     = b_stb_q;
    start_d     = start_q;
    z_ack_d     = 1'b0;
    rsp_valid_d = rsp_valid_q;
    count_d     = count_q;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          a_d     = sel_a;
          b_d     = sel_b;
          grant_d = pick_idx;
          a_stb_d = 1'b1;
          b_stb_d = 1'b1;
          start_d = 1'b1;
          state_d = LOAD;
        end
      end

      LOAD: begin
        if (a_stb_q && bus.add_a_ack) a_stb_d = 1'b0;
        if (b_stb_q && bus.add_b_ack) b_stb_d = 1'b0;
        if (!a_stb_d && !b_stb_d) state_d = WAIT_Z;
      end

      WAIT_Z: begin
        if (bus.add_z_stb) begin
          z_d                  = bus.add_z;
          z_ack_d              = 1'b1;
          start_d              = 1'b0;
          rsp_valid_d          = '0;
          rsp_valid_d[grant_q] = 1'b1;
          state_d              = RESP;
        end
      end

      RESP: begin
        if (bus.rsp_ready[grant_q]) begin
          rsp_valid_d = '0;
          if (count_q != '1) count_d = count_q + 1'b1;
          if (grant_q == IDW'(NUM_REQ - 1)) ptr_d = '0;
          else                              ptr_d = grant_q + 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      z_q         <= '0;
      a_stb_q     <= 1'b0;
      b_stb_q     <= 1'b0;
      start_q     <= 1'b0;
      z_ack_q     <= 1'b0;
      rsp_valid_q <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      a_q         <= a_d;
      b_q         <= b_d;
      z_q         <= z_d;
      a_stb_q     <= a_stb_d;
      b_stb_q     <= b_stb_d;
      start_q     <= start_d;
      z_ack_q     <= z_ack_d;
      rsp_valid_q <= rsp_valid_d;
      count_q     <= count_d;
    end
  end

  assign bus.add_a     = a_q;
  assign bus.add_b     = b_q;
  assign bus.add_a_stb = a_stb_q;
  assign bus.add_b_stb = b_stb_q;
  assign bus.add_start = start_q;
  assign bus.add_z_ack = z_ack_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_z     = z_q;

  assign busy_o     = (state_q != IDLE);
  assign grant_id_o = grant_q;
  assign op_count_o = count_q;

endmodule

// File: tb/tb_fpu_add_arbiter.sv
// Scoreboard bench for fpu_add_arbiter: requester queues, a handshake-level
// adder model with hand-computed sums, and a monitor comparing responses.
`timescale 1ns/1ps
module tb_fpu_add_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int CNTW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            busy;
  logic [1:0]      grantId;
  logic [CNTW-1:0] opCount;

  fpu_add_arbiter_if #(.NUM_REQ(NREQ), .WIDTH(W)) bus ();

  fpu_add_arbiter #(.NUM_REQ(NREQ), .WIDTH(W), .CNT_W(CNTW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .busy_o     (busy),
    .grant_id_o (grantId),
    .op_count_o (opCount)
  );

  initial forever #5 clk = ~clk;

  int              checkCount = 0;
  int              passCount  = 0;
  logic [63:0]     reqQ [NREQ][$];
  logic [31:0]     expQ [NREQ][$];
  int              expGrantQ [$];
  logic [NREQ-1:0] rspReadyMask = '1;
  int              aDelay = 0;
  int              bDelay = 0;
  int              zLatency = 1;
  int              zAckCount = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
  endtask

  task automatic timeoutFail(input string name);
    checkCount++;
    $display("[TB] FAIL %s timeout actual=waiting expected=event", name);
  endtask

  task automatic applyStimulus(input int id, input logic [31:0] a, input logic [31:0] b, input logic [31:0] z);
    reqQ[id].push_back({a, b});
    expQ[id].push_back(z);
  endtask

  task automatic expectGrant(input int g);
    expGrantQ.push_back(g);
  endtask

  task automatic sampleStep();
    @(negedge clk);
    #4;
  endtask

  function automatic bit allIdle();
    bit r;
    r = !busy && (bus.rsp_valid == '0) && (expGrantQ.size() == 0);
    for (int i = 0; i < NREQ; i++) begin
      if (reqQ[i].size() != 0 || expQ[i].size() != 0) r = 1'b0;
    end
    return r;
  endfunction

  task automatic waitDrain(input string name, input int budget);
    int n;
    n = 0;
    sampleStep();
    while (!allIdle() && n < budget) begin
      sampleStep();
      n++;
    end
    if (n >= budget) timeoutFail(name);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      reqQ[i].delete();
      expQ[i].delete();
    end
    expGrantQ.delete();
    rspReadyMask = '1;
    aDelay = 0;
    bDelay = 0;
    zLatency = 1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Hand-computed IEEE-754 single sums for the operand pairs used below.
  function automatic logic [31:0] fpLookup(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h433E95C3_40E80000: return 32'h4345D5C3;
      64'h3F800000_40000000: return 32'h40400000;
      64'h3F800000_3F800000: return 32'h40000000;
      64'h40000000_40000000: return 32'h40800000;
      64'h3F000000_3F000000: return 32'h3F800000;
      64'h40400000_3F800000: return 32'h40800000;
      default:               return 32'hDEADBEEF;
    endcase
  endfunction

  // Requesters present the head of their queue and pop it after an accept.
  initial begin : requesterDriver
    logic [NREQ-1:0]   accSeen;
    logic [NREQ*W-1:0] aVec, bVec;
    accSeen = '0;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = '1;
    forever begin
      @(negedge clk);
      aVec = '0;
      bVec = '0;
      for (int i = 0; i < NREQ; i++) begin
        if (accSeen[i] && reqQ[i].size() > 0) void'(reqQ[i].pop_front());
      end
      for (int i = 0; i < NREQ; i++) begin
        if (reqQ[i].size() > 0) begin
          bus.req_valid[i] = 1'b1;
          aVec[i*W +: W] = reqQ[i][0][63:32];
          bVec[i*W +: W] = reqQ[i][0][31:0];
        end else begin
          bus.req_valid[i] = 1'b0;
        end
      end
      bus.req_a = aVec;
      bus.req_b = bVec;
      bus.rsp_ready = rspReadyMask;
      #3;
      accSeen = bus.req_ready;
    end
  end

  // Adder model: acks each operand after its delay, then strobes the sum.
  initial begin : adderModel
    int aCnt, bCnt, zCnt;
    bit aTaken, bTaken;
    logic [31:0] opA, opB;
    aCnt = 0; bCnt = 0; zCnt = 0; aTaken = 0; bTaken = 0; opA = '0; opB = '0;
    bus.add_a_ack = 1'b0;
    bus.add_b_ack = 1'b0;
    bus.add_z_stb = 1'b0;
    bus.add_z = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        aCnt = 0; bCnt = 0; zCnt = 0; aTaken = 0; bTaken = 0;
        bus.add_a_ack = 1'b0;
        bus.add_b_ack = 1'b0;
        bus.add_z_stb = 1'b0;
        continue;
      end
      if (bus.add_a_stb && !aTaken) begin
        if (aCnt >= aDelay) begin
          bus.add_a_ack = 1'b1; aTaken = 1; opA = bus.add_a;
        end else aCnt++;
      end else bus.add_a_ack = 1'b0;
      if (bus.add_b_stb && !bTaken) begin
        if (bCnt >= bDelay) begin
          bus.add_b_ack = 1'b1; bTaken = 1; opB = bus.add_b;
        end else bCnt++;
      end else bus.add_b_ack = 1'b0;
      if (bus.add_z_stb) begin
        if (bus.add_z_ack) begin
          bus.add_z_stb = 1'b0;
          aCnt = 0; bCnt = 0; zCnt = 0; aTaken = 0; bTaken = 0;
        end
      end else if (aTaken && bTaken) begin
        if (zCnt >= zLatency) begin
          bus.add_z_stb = 1'b1;
          bus.add_z = fpLookup(opA, opB);
        end else zCnt++;
      end
    end
  end

  // Monitor: grant order on accepts, result/id on responses, count model.
  initial begin : monitor
    logic [NREQ-1:0] prevValid;
    logic [31:0]     heldZ;
    int              lastAccepted;
    int              expCount;
    int              g;
    prevValid = '0; heldZ = '0; lastAccepted = 0; expCount = 0;
    forever begin
      sampleStep();
      if (rst) begin
        prevValid = '0;
        expCount = 0;
        continue;
      end
      if (bus.add_z_ack) zAckCount++;
      if (bus.req_ready != '0) begin
        checkOutput("req_ready onehot", 64'($countones(bus.req_ready)), 64'd1);
        checkOutput("accept while busy", 64'(busy), 64'd0);
        g = 0;
        for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) g = i;
        lastAccepted = g;
        if (expGrantQ.size() > 0) checkOutput("grant order", 64'(g), 64'(expGrantQ.pop_front()));
        else begin
          checkCount++;
          $display("[TB] FAIL unexpected accept actual=%0d expected=none", g);
        end
      end
      if (bus.rsp_valid != '0) begin
        if (prevValid == bus.rsp_valid) begin
          checkOutput("rsp_z stable", 64'(bus.rsp_z), 64'(heldZ));
        end else begin
          checkOutput("rsp_valid granted bit", 64'(bus.rsp_valid), 64'(1) << lastAccepted);
          checkOutput("grant_id", 64'(grantId), 64'(lastAccepted));
          heldZ = bus.rsp_z;
          if (expQ[lastAccepted].size() > 0)
            checkOutput("rsp_z", 64'(bus.rsp_z), 64'(expQ[lastAccepted].pop_front()));
          else begin
            checkCount++;
            $display("[TB] FAIL unexpected response actual=0x%0h expected=none", bus.rsp_z);
          end
        end
        if ((bus.rsp_valid & bus.rsp_ready) != '0) begin
          checkOutput("op_count", 64'(opCount), 64'(expCount));
          if (expCount < (1 << CNTW) - 1) expCount++;
        end
      end
      prevValid = bus.rsp_valid;
    end
  end

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int z0, n;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset req_ready", 64'(bus.req_ready), 64'd0);
    checkOutput("reset rsp_valid", 64'(bus.rsp_valid), 64'd0);
    checkOutput("reset strobes", 64'({bus.add_a_stb, bus.add_b_stb, bus.add_start, bus.add_z_ack}), 64'd0);
    checkOutput("reset op_count", 64'(opCount), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] single request");
    z0 = zAckCount;
    applyStimulus(0, 32'h433E95C3, 32'h40E80000, 32'h4345D5C3);
    expectGrant(0);
    waitDrain("single drain", 100);
    checkOutput("single op_count", 64'(opCount), 64'd1);
    checkOutput("single z_ack pulses", 64'(zAckCount - z0), 64'd1);

    $display("[TB] all requesters continuously valid");
    doReset();
    for (int i = 0; i < NREQ; i++) applyStimulus(i, 32'h3F800000, 32'h40000000, 32'h40400000);
    applyStimulus(0, 32'h3F800000, 32'h40000000, 32'h40400000);
    expectGrant(0); expectGrant(1); expectGrant(2); expectGrant(3); expectGrant(0);
    waitDrain("all drain", 200);
    checkOutput("all op_count", 64'(opCount), 64'd5);

    $display("[TB] distinct operands per requester");
    doReset();
    applyStimulus(0, 32'h3F000000, 32'h3F000000, 32'h3F800000);
    applyStimulus(1, 32'h40400000, 32'h3F800000, 32'h40800000);
    applyStimulus(3, 32'h433E95C3, 32'h40E80000, 32'h4345D5C3);
    expectGrant(0); expectGrant(1); expectGrant(3);
    waitDrain("distinct drain", 200);
    checkOutput("distinct op_count", 64'(opCount), 64'd3);

    $display("[TB] split acks");
    doReset();
    aDelay = 0;
    bDelay = 2;
    applyStimulus(1, 32'h3F800000, 32'h3F800000, 32'h40000000);
    expectGrant(1);
    n = 0;
    sampleStep();
    while (!(bus.add_a_stb && bus.add_b_stb) && n < 50) begin sampleStep(); n++; end
    if (n >= 50) timeoutFail("split strobes");
    sampleStep();
    checkOutput("split cyc1 strobes", 64'({bus.add_a_stb, bus.add_b_stb}), 64'b01);
    sampleStep();
    checkOutput("split cyc2 strobes", 64'({bus.add_a_stb, bus.add_b_stb}), 64'b01);
    sampleStep();
    checkOutput("split after both", 64'({bus.add_a_stb, bus.add_b_stb, bus.add_start}), 64'b001);
    waitDrain("split drain", 100);

    $display("[TB] responder stall");
    doReset();
    rspReadyMask = 4'b1101;
    z0 = zAckCount;
    applyStimulus(1, 32'h40000000, 32'h40000000, 32'h40800000);
    expectGrant(1);
    n = 0;
    sampleStep();
    while (!bus.rsp_valid[1] && n < 50) begin sampleStep(); n++; end
    if (n >= 50) timeoutFail("stall response");
    applyStimulus(0, 32'h3F800000, 32'h40000000, 32'h40400000);
    expectGrant(0);
    for (int c = 0; c < 10; c++) begin
      sampleStep();
      checkOutput("stall rsp_valid", 64'(bus.rsp_valid), 64'b0010);
      checkOutput("stall no accept", 64'(bus.req_ready), 64'd0);
    end
    checkOutput("stall z_ack pulses", 64'(zAckCount - z0), 64'd1);
    rspReadyMask = '1;
    waitDrain("stall drain", 100);
    checkOutput("stall op_count", 64'(opCount), 64'd2);

    $display("[TB] reset mid-operation");
    doReset();
    zLatency = 5;
    applyStimulus(2, 32'h3F000000, 32'h3F000000, 32'h3F800000);
    expectGrant(2);
    n = 0;
    sampleStep();
    while (!(bus.add_start && !bus.add_a_stb && !bus.add_b_stb) && n < 50) begin sampleStep(); n++; end
    if (n >= 50) timeoutFail("reset wait_z");
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midrst busy", 64'(busy), 64'd0);
    checkOutput("midrst add_start", 64'(bus.add_start), 64'd0);
    checkOutput("midrst grant_id", 64'(grantId), 64'd0);
    checkOutput("midrst add_a", 64'(bus.add_a), 64'd0);
    checkOutput("midrst rsp_z", 64'(bus.rsp_z), 64'd0);
    for (int i = 0; i < NREQ; i++) begin reqQ[i].delete(); expQ[i].delete(); end
    expGrantQ.delete();
    zLatency = 1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    applyStimulus(2, 32'h3F800000, 32'h3F800000, 32'h40000000);
    applyStimulus(1, 32'h40000000, 32'h40000000, 32'h40800000);
    expectGrant(1); expectGrant(2);
    waitDrain("midrst drain", 200);

    $display("[TB] pointer wrap");
    doReset();
    applyStimulus(3, 32'h3F800000, 32'h40000000, 32'h40400000);
    expectGrant(3);
    waitDrain("wrap first", 100);
    applyStimulus(3, 32'h40400000, 32'h3F800000, 32'h40800000);
    applyStimulus(0, 32'h3F000000, 32'h3F000000, 32'h3F800000);
    expectGrant(0); expectGrant(3);
    waitDrain("wrap second", 200);

    $display("[TB] op_count saturation");
    doReset();
    for (int i = 0; i < 17; i++) begin
      applyStimulus(0, 32'h3F000000, 32'h3F000000, 32'h3F800000);
      expectGrant(0);
    end
    waitDrain("sat drain", 1000);
    checkOutput("sat op_count", 64'(opCount), 64'd15);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/fpu_add_arbiter.md
Name: fpu_add_arbiter

Overview:
Round-robin arbiter and sequencer that shares one single-precision FP adder among NUM_REQ requesters. It accepts an operand pair from one requester and drives the adder's a/b strobe-ack handshake. It then collects the result through the adder's z strobe-ack handshake and returns the sum to the granted requester. It sits between the FPU's client ports and the adder instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 32, operand/result width (IEEE-754 single)
CNT_W, 16, width of completed-operation counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
req_valid  input  NUM_REQ  requester i has an operand pair ready
req_a  input  NUM_REQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH]
req_b  input  NUM_REQ*WIDTH  operand B, same packing
req_ready  output  NUM_REQ  one-cycle accept pulse to the granted requester
rsp_valid  output  NUM_REQ  result valid for requester i (one-hot)
rsp_z  output  WIDTH  result, shared bus
rsp_ready  input  NUM_REQ  requester i takes the result
add_a, add_b  output  WIDTH  adder operands
add_a_stb, add_b_stb  output  1  adder operand strobes
add_a_ack, add_b_ack  input  1  adder operand acks
add_start  output  1  adder start enable
add_z  input  WIDTH  adder result
add_z_stb  input  1  adder result strobe
add_z_ack  output  1  result ack to adder
busy  output  1  high in every state except IDLE
grant_id  output  clog2(NUM_REQ)  index of the current/last grant
op_count  output  CNT_W  completed operations, saturating

Behaviour:
- Reset (async, any state): FSM to IDLE. All outputs go to 0, and the round-robin pointer goes to 0. Operands and results in flight are discarded. The adder shares rst.
- States: IDLE, LOAD, WAIT_Z, RESP.
- IDLE:
  - If any req_valid is set, pick the first set bit at or after the pointer, wrapping modulo NUM_REQ.
  - Latch that requester's req_a/req_b into add_a/add_b and pulse req_ready[g] for exactly 1 cycle.
  - Set grant_id to g. Next state is LOAD, where add_a_stb, add_b_stb and add_start rise one cycle after the accept.
- LOAD:
  - add_a_stb holds until add_a_ack is sampled high, then drops the next cycle. add_b_stb follows the same rule independently.
  - The two acks may arrive in the same cycle or in different cycles.
  - Move to WAIT_Z once both acks have been seen. add_a/add_b stay stable while their strobe is high.
- WAIT_Z: add_start stays high. When add_z_stb is sampled high:
  - latch add_z into rsp_z;
  - assert add_z_ack for exactly 1 cycle;
  - drop add_start;
  - go to RESP.
- RESP:
  - rsp_valid[g] holds with rsp_z stable until rsp_ready[g] is sampled high.
  - The next cycle: rsp_valid clears, op_count increments (saturating at all-ones), pointer becomes (g+1) mod NUM_REQ, state returns to IDLE.
  - rsp_ready on non-granted bits is ignored.
- One operation is in flight at a time. Requests arriving while busy wait; req_valid must stay high until req_ready.
- Minimum service time, with acks in the same cycle and 0-cycle responder: 1 (accept) + 1 (LOAD) + adder latency + 1 (z ack) + 1 (RESP) cycles. Next accept is no earlier than the cycle after RESP exits.
- Starvation-free: a requester that stays valid is served within NUM_REQ grants.
- Requests that drop before being granted are ignored without error.

Test Plan:
- Single request: req0 a=0x433E95C3 (190.585), b=0x40E80000 (7.25) -> req_ready[0] pulses 1 cycle; adder strobes then add_z_ack pulse; rsp_valid[0] with rsp_z=0x4345D5C3 (197.835); op_count=1.
- All four requesters valid continuously, req i: a=0x3F800000, b=0x40000000 -> grants in order 0,1,2,3,0; each rsp_z=0x40400000 (3.0); no rsp_valid on a non-granted bit.
- Split acks: add_a_ack 2 cycles before add_b_ack -> add_a_stb drops after its ack, add_b_stb holds; WAIT_Z entered only after both acks.
- Responder stall: rsp_ready[1] held low for 10 cycles -> rsp_valid[1] and rsp_z stable; no new req_ready during the stall; add_z_ack pulsed exactly once.
- Reset mid-op: rst asserted in WAIT_Z -> same cycle all outputs 0, busy=0; after release, req2 is granted first only if req0/req1 are idle (pointer=0).
- Pointer wrap: grant req3, then req0 and req3 both valid -> req0 granted next.
